// File: rtl/meteor_ctrl_pkg.sv
// Shared screen constants, FSM encoding and spawn-column helper for the meteor game.
package meteor_ctrl_pkg;

    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned X_MIN    = 7;
    localparam int unsigned X_MAX    = 632;
    localparam int unsigned X_SPAN   = X_MAX - X_MIN;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned COORD_W  = 16;
    localparam int unsigned RND_W    = 10;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SPAWN = 2'd1;
    localparam logic [STATE_W-1:0] ST_FALL  = 2'd2;
    localparam logic [STATE_W-1:0] ST_HIT   = 2'd3;

    // Fold a 10-bit random value into X_MIN..X_MAX with a single conditional subtract.
    function automatic logic [COORD_W-1:0] spawn_column(input logic [RND_W-1:0] rnd);
        logic [RND_W-1:0] r;
        r = rnd;
        if (r > RND_W'(X_SPAN))
            r = r - RND_W'(X_SPAN + 1);
        return COORD_W'(X_MIN) + COORD_W'(r);
    endfunction

endpackage

// File: rtl/meteor_ctrl_if.sv
// Control inputs and meteor position/status outputs of meteor_ctrl.
interface meteor_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic        pause;
    logic        hit;
    logic [15:0] meteor;
    logic [15:0] move;
    logic        active;
    logic        game_over;
    logic [3:0]  speed;
    logic [7:0]  dodged;

    modport master (
        output frame_tick, start, pause, hit,
        input  meteor, move, active, game_over, speed, dodged
    );

    modport slave (
        input  frame_tick, start, pause, hit,
        output meteor, move, active, game_over, speed, dodged
    );
endinterface

// File: rtl/meteor_ctrl_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the low bits used for spawning.
module meteor_lfsr
    import meteor_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [RND_W-1:0] rnd
);

    logic [15:0] state;
    logic        feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];
    assign rnd      = state[RND_W-1:0];

    // Shift every clock regardless of game state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= SEED;
        else
            state <= {state[14:0], feedback};
    end

endmodule

// File: rtl/meteor_ctrl.sv
// Meteor spawn/fall/recycle/collision sequencer feeding the meteor renderer.
module meteor_ctrl
    import meteor_ctrl_pkg::*;
#(
    parameter int unsigned SPEED_INIT   = 2,
    parameter int unsigned SPEED_MAX    = 8,
    parameter int unsigned LEVEL_DODGES = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic          clock,
    input  logic          reset_n,
    meteor_ctrl_if.slave  bus
);

    logic [STATE_W-1:0] state, state_nxt;
    logic [RND_W-1:0]   rnd;
    logic [COORD_W-1:0] meteor_nxt, move_nxt;
    logic               active_nxt, game_over_nxt;
    logic [3:0]         speed_nxt;
    logic [7:0]         dodged_nxt, dodged_inc;
    logic [COORD_W:0]   sum;

    meteor_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .rnd     (rnd)
    );

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bus.meteor    <= '0;
            bus.move      <= '0;
            bus.active    <= 1'b0;
            bus.game_over <= 1'b0;
            bus.speed     <= 4'(SPEED_INIT);
            bus.dodged    <= '0;
        end else begin
            state         <= state_nxt;
            bus.meteor    <= meteor_nxt;
            bus.move      <= move_nxt;
            bus.active    <= active_nxt;
            bus.game_over <= game_over_nxt;
            bus.speed     <= speed_nxt;
            bus.dodged    <= dodged_nxt;
        end
    end

    // Next state and next output values; priority in FALL is hit > start > frame_tick.
    always_comb begin
        state_nxt     = state;
        meteor_nxt    = bus.meteor;
        move_nxt      = bus.move;
        active_nxt    = bus.active;
        game_over_nxt = bus.game_over;
        speed_nxt     = bus.speed;
        dodged_nxt    = bus.dodged;
        sum           = {1'b0, bus.move} + (COORD_W+1)'(bus.speed);
        dodged_inc    = bus.dodged + 8'd1;

        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = ST_SPAWN;
            end
            ST_SPAWN: begin
                meteor_nxt = spawn_column(rnd);
                move_nxt   = '0;
                active_nxt = 1'b1;
                state_nxt  = ST_FALL;
            end
            ST_FALL: begin
                if (bus.hit) begin
                    game_over_nxt = 1'b1;
                    state_nxt     = ST_HIT;
                end else if (bus.start) begin
                    speed_nxt  = 4'(SPEED_INIT);
                    dodged_nxt = '0;
                    state_nxt  = ST_SPAWN;
                end else if (bus.frame_tick && !bus.pause) begin
                    if (sum >= (COORD_W+1)'(SCREEN_H)) begin
                        dodged_nxt = dodged_inc;
                        if ((dodged_inc % 8'(LEVEL_DODGES)) == 8'd0 && bus.speed < 4'(SPEED_MAX))
                            speed_nxt = bus.speed + 4'd1;
                        active_nxt = 1'b0;
                        state_nxt  = ST_SPAWN;
                    end else begin
                        move_nxt = sum[COORD_W-1:0];
                    end
                end
            end
            ST_HIT: begin
                if (bus.start) begin
                    speed_nxt     = 4'(SPEED_INIT);
                    dodged_nxt    = '0;
                    game_over_nxt = 1'b0;
                    state_nxt     = ST_SPAWN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_meteor_ctrl.sv
// Directed bench for meteor_ctrl: reset, falling, recycling, speed levels, hit, pause, restart.
module tb_meteor_ctrl;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    logic [15:0] ml;
    logic [15:0] col_exp;

    meteor_ctrl_if bus ();

    meteor_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: 16-bit, taps 16,14,13,11, shifting left.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ml <= 16'hACE1;
        else
            ml <= {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
    end

    function automatic logic [15:0] exp_col(input logic [15:0] l);
        int r;
        r = int'(l[9:0]);
        if (r > 625)
            r = r - 626;
        return 16'(7 + r);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++)
            frame();
    endtask

    // Hold frame_tick until the meteor is recycled, then step through SPAWN.
    task automatic run_dodge(input string tag, input int exp_ticks);
        int n;
        n = 0;
        bus.frame_tick = 1'b1;
        while (n < 2000) begin
            tick();
            n++;
            if (bus.active == 1'b0)
                break;
        end
        bus.frame_tick = 1'b0;
        check(tag, 32'(n), 32'(exp_ticks));
        tick();
    endtask

    initial begin
        int s_before;
        int s_after;
        total = 0;
        bad   = 0;
        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.hit        = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Idle with no start.
        repeat (100) tick();
        check("idle_active", 32'(bus.active), 32'd0);
        check("idle_move", 32'(bus.move), 32'd0);
        check("idle_meteor", 32'(bus.meteor), 32'd0);
        check("idle_speed", 32'(bus.speed), 32'd2);
        check("idle_game_over", 32'(bus.game_over), 32'd0);
        check("idle_dodged", 32'(bus.dodged), 32'd0);
        frames(3);
        check("idle_ignores_tick", 32'(bus.move), 32'd0);

        // Start and first spawn.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        col_exp = exp_col(ml);
        check("spawn_active_low", 32'(bus.active), 32'd0);
        tick();
        check("spawn1_meteor", 32'(bus.meteor), 32'(col_exp));
        check("spawn1_range", 32'(bus.meteor >= 16'd7 && bus.meteor <= 16'd632), 32'd1);
        check("spawn1_active", 32'(bus.active), 32'd1);
        check("spawn1_move", 32'(bus.move), 32'd0);

        for (int i = 1; i <= 10; i++) begin
            frame();
            check($sformatf("fall_move_%0d", i), 32'(bus.move), 32'(2 * i));
        end

        // Fall to the bottom: 20 + 229*2 = 478, next tick recycles.
        frames(229);
        check("bottom_move", 32'(bus.move), 32'd478);
        frame();
        check("recycle_active", 32'(bus.active), 32'd0);
        check("recycle_dodged", 32'(bus.dodged), 32'd1);
        col_exp = exp_col(ml);
        tick();
        check("respawn_move", 32'(bus.move), 32'd0);
        check("respawn_active", 32'(bus.active), 32'd1);
        check("respawn_meteor", 32'(bus.meteor), 32'(col_exp));

        // Dodges 2..28: speed steps every 4 dodges and saturates at 8.
        for (int d = 2; d <= 28; d++) begin
            s_before = 2 + (d - 1) / 4;
            if (s_before > 8) s_before = 8;
            s_after = 2 + d / 4;
            if (s_after > 8) s_after = 8;
            run_dodge($sformatf("dodge_%0d_ticks", d), (480 + s_before - 1) / s_before);
            check($sformatf("dodge_%0d_count", d), 32'(bus.dodged), 32'(d));
            check($sformatf("dodge_%0d_speed", d), 32'(bus.speed), 32'(s_after));
        end

        // Hit together with frame_tick at move 96 (speed 8).
        frames(12);
        check("pre_hit_move", 32'(bus.move), 32'd96);
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        tick();
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        check("hit_game_over", 32'(bus.game_over), 32'd1);
        check("hit_move", 32'(bus.move), 32'd96);
        check("hit_active", 32'(bus.active), 32'd1);
        frames(3);
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        check("hit_frozen_move", 32'(bus.move), 32'd96);
        check("hit_frozen_game_over", 32'(bus.game_over), 32'd1);

        // Restart from HIT.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_game_over", 32'(bus.game_over), 32'd0);
        check("restart_speed", 32'(bus.speed), 32'd2);
        check("restart_dodged", 32'(bus.dodged), 32'd0);
        col_exp = exp_col(ml);
        tick();
        check("restart_meteor", 32'(bus.meteor), 32'(col_exp));
        check("restart_move", 32'(bus.move), 32'd0);

        // Pause holds the meteor.
        frames(50);
        check("pause_pre_move", 32'(bus.move), 32'd100);
        bus.pause = 1'b1;
        frames(5);
        check("paused_move", 32'(bus.move), 32'd100);
        bus.pause = 1'b0;
        frame();
        check("unpaused_move", 32'(bus.move), 32'd102);

        // 102 + 189*2 = 480 recycles.
        run_dodge("dodge_from_102_ticks", 189);
        check("dodge_from_102_count", 32'(bus.dodged), 32'd1);

        // start beats frame_tick in FALL.
        frames(5);
        bus.start = 1'b1;
        bus.frame_tick = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.frame_tick = 1'b0;
        check("fall_restart_move", 32'(bus.move), 32'd10);
        check("fall_restart_dodged", 32'(bus.dodged), 32'd0);
        check("fall_restart_speed", 32'(bus.speed), 32'd2);
        tick();
        check("fall_restart_spawn_move", 32'(bus.move), 32'd0);

        // hit beats start in FALL.
        frames(2);
        bus.hit = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.hit = 1'b0;
        bus.start = 1'b0;
        check("hit_over_start", 32'(bus.game_over), 32'd1);
        check("hit_over_start_move", 32'(bus.move), 32'd4);

        // hit during SPAWN is ignored.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        check("spawn_hit_game_over", 32'(bus.game_over), 32'd0);
        check("spawn_hit_active", 32'(bus.active), 32'd1);
        frame();
        check("spawn_hit_then_fall", 32'(bus.move), 32'd2);

        // Asynchronous reset at move 200.
        frames(99);
        check("pre_reset_move", 32'(bus.move), 32'd200);
        reset_n = 1'b0;
        #1;
        check("rst_move", 32'(bus.move), 32'd0);
        check("rst_meteor", 32'(bus.meteor), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_speed", 32'(bus.speed), 32'd2);
        check("rst_dodged", 32'(bus.dodged), 32'd0);
        tick();
        reset_n = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        // Seed ACE1 steps once to 59C3; low 10 bits 451 -> column 458.
        check("golden_spawn_meteor", 32'(bus.meteor), 32'd458);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
